// File: rtl/recovery_pkg.sv
`default_nettype none
// ============================================================================
// Module   : recovery_pkg
// Purpose  : Shared types and constants for the misprediction recovery
//            sequencer (FSM state encoding, FU busy-vector bit positions).
// Revision : 1.0 - initial release
// ============================================================================
package recovery_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_RESTORE  = 3'd3,
    ST_REDIRECT = 3'd4
  } recovery_state_t;

  // Bit positions inside the {alu, fpu, lsu, bru} busy vector
  localparam int FU_ALU = 3;
  localparam int FU_FPU = 2;
  localparam int FU_LSU = 1;
  localparam int FU_BRU = 0;

endpackage
`default_nettype wire

// File: rtl/recovery_drain_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : recovery_drain_watchdog
// Purpose  : Counts cycles spent in DRAIN and flags a stuck drain after
//            DRAIN_TIMEOUT cycles. The flag is sticky until reset.
//            Built only when RECOVERY_DRAIN_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module recovery_drain_watchdog #(
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_in_drain,
  input  logic i_fu_busy,
  output logic o_expire,
  output logic o_timeout
);

  localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  // Expiry fires on the final allowed DRAIN cycle while work is still in flight
  assign o_expire  = i_in_drain && i_fu_busy && (r_cnt == C_LAST);
  assign o_timeout = r_timeout;

  // Cycle counter restarts on every DRAIN entry; sticky error flag
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!i_in_drain) begin
        r_cnt <= '0;
      end else if (r_cnt != C_LAST) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (o_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : recovery_ctrl
// Purpose  : Misprediction recovery sequencer: flush, drain in-flight FU
//            work, copy RRAT into RAT in RESTORE_WIDTH-wide beats, then
//            redirect fetch to the corrected PC. All outputs are registered.
// Options  : RECOVERY_DRAIN_TIMEOUT_EN - builds the drain watchdog that
//            forces RESTORE and raises drain_timeout_out on a stuck drain.
// Revision : 1.0 - initial release
// ============================================================================
module recovery_ctrl #(
  parameter int NUM_ARCH_REGS = 32,
  parameter int RESTORE_WIDTH = 4,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             mispredict_valid_in,
  input  logic [63:0]                      mispredict_pc_in,
  input  logic [3:0]                       fu_busy_in,
  input  logic                             redirect_ready_in,
  output logic                             flush_out,
  output logic                             stall_out,
  output logic                             restore_valid_out,
  output logic [$clog2(NUM_ARCH_REGS)-1:0] restore_base_out,
  output logic [RESTORE_WIDTH-1:0]         restore_lane_valid_out,
  output logic                             redirect_valid_out,
  output logic [63:0]                      redirect_pc_out,
  output logic                             busy_out,
  output logic                             drain_timeout_out
);

  import recovery_pkg::*;

  localparam int IDX_W  = $clog2(NUM_ARCH_REGS);
  localparam int BEATS  = (NUM_ARCH_REGS + RESTORE_WIDTH - 1) / RESTORE_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BEATS - 1);

  generate
    if (RESTORE_WIDTH < 1 || DRAIN_TIMEOUT < 1) begin : g_bad_param
      $error("recovery_ctrl: RESTORE_WIDTH and DRAIN_TIMEOUT must be >= 1");
    end
  endgenerate

  // Lane i of beat k is live only while k*W+i still names a real register
  function automatic logic [RESTORE_WIDTH-1:0] lane_mask(input logic [BEAT_W-1:0] k);
    logic [RESTORE_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < RESTORE_WIDTH; i++) begin
      m[i] = ((int'(k) * RESTORE_WIDTH + i) < NUM_ARCH_REGS);
    end
    return m;
  endfunction

  function automatic logic [IDX_W-1:0] beat_base(input logic [BEAT_W-1:0] k);
    int b;
    b = int'(k) * RESTORE_WIDTH;
    return b[IDX_W-1:0];
  endfunction

  recovery_state_t           r_state, w_state_nxt;
  logic [BEAT_W-1:0]         r_beat, w_beat_nxt;
  logic [63:0]               r_pc, w_pc_nxt;
  logic                      r_flush;
  logic                      r_busy;
  logic                      r_restore_valid;
  logic [IDX_W-1:0]          r_restore_base;
  logic [RESTORE_WIDTH-1:0]  r_lane_valid;
  logic                      r_redirect_valid;
  logic [63:0]               r_redirect_pc;
  logic                      w_fu_idle;
  logic                      w_drain_expire;

  assign w_fu_idle = ~|{fu_busy_in[FU_ALU], fu_busy_in[FU_FPU],
                        fu_busy_in[FU_LSU], fu_busy_in[FU_BRU]};

`ifdef RECOVERY_DRAIN_TIMEOUT_EN
  logic w_timeout;

  recovery_drain_watchdog #(
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) u_watchdog (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_in_drain (r_state == ST_DRAIN),
    .i_fu_busy  (!w_fu_idle),
    .o_expire   (w_drain_expire),
    .o_timeout  (w_timeout)
  );

  assign drain_timeout_out = w_timeout;
`else
  assign w_drain_expire    = 1'b0;
  assign drain_timeout_out = 1'b0;
`endif

  // Next-state, beat counter and PC latch
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_IDLE: begin
        if (mispredict_valid_in) begin
          w_state_nxt = ST_FLUSH;
          w_pc_nxt    = mispredict_pc_in;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_DRAIN;
        w_beat_nxt  = '0;
      end
      ST_DRAIN: begin
        if (w_fu_idle || w_drain_expire) begin
          w_state_nxt = ST_RESTORE;
        end
      end
      ST_RESTORE: begin
        if (r_beat == C_LAST_BEAT) begin
          w_state_nxt = ST_REDIRECT;
        end else begin
          w_beat_nxt = r_beat + BEAT_W'(1);
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready_in) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_flush          <= 1'b0;
      r_busy           <= 1'b0;
      r_restore_valid  <= 1'b0;
      r_restore_base   <= '0;
      r_lane_valid     <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_flush          <= (w_state_nxt == ST_FLUSH);
      r_busy           <= (w_state_nxt != ST_IDLE);
      r_restore_valid  <= (w_state_nxt == ST_RESTORE);
      r_restore_base   <= (w_state_nxt == ST_RESTORE) ? beat_base(w_beat_nxt) : '0;
      r_lane_valid     <= (w_state_nxt == ST_RESTORE) ? lane_mask(w_beat_nxt) : '0;
      r_redirect_valid <= (w_state_nxt == ST_REDIRECT);
      r_redirect_pc    <= (w_state_nxt == ST_REDIRECT) ? w_pc_nxt : '0;
    end
  end

  assign flush_out              = r_flush;
  assign stall_out              = r_busy;
  assign busy_out               = r_busy;
  assign restore_valid_out      = r_restore_valid;
  assign restore_base_out       = r_restore_base;
  assign restore_lane_valid_out = r_lane_valid;
  assign redirect_valid_out     = r_redirect_valid;
  assign redirect_pc_out        = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_recovery_ctrl
// Purpose  : Directed self-checking bench for recovery_ctrl. Two instances
//            share stimulus: 32 regs x 4 lanes and 10 regs x 4 lanes.
//            Timeout scenario runs when RECOVERY_DRAIN_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_recovery_ctrl;

`ifdef RECOVERY_DRAIN_TIMEOUT_EN
  localparam int DRAIN_CYC = 10;
`else
  localparam int DRAIN_CYC = 20;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        mp_valid = 1'b0;
  logic [63:0] mp_pc = '0;
  logic [3:0]  fu_busy = '0;
  logic        rdy = 1'b0;

  logic        flush_a, stall_a, rv_a, redv_a, busy_a, to_a;
  logic [4:0]  base_a;
  logic [3:0]  lanes_a;
  logic [63:0] rpc_a;
  logic        flush_b, stall_b, rv_b, redv_b, busy_b, to_b;
  logic [3:0]  base_b;
  logic [3:0]  lanes_b;
  logic [63:0] rpc_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  recovery_ctrl #(.NUM_ARCH_REGS(32), .RESTORE_WIDTH(4), .DRAIN_TIMEOUT(16)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .mispredict_valid_in(mp_valid),
    .mispredict_pc_in(mp_pc), .fu_busy_in(fu_busy), .redirect_ready_in(rdy),
    .flush_out(flush_a), .stall_out(stall_a), .restore_valid_out(rv_a),
    .restore_base_out(base_a), .restore_lane_valid_out(lanes_a),
    .redirect_valid_out(redv_a), .redirect_pc_out(rpc_a), .busy_out(busy_a),
    .drain_timeout_out(to_a)
  );

  recovery_ctrl #(.NUM_ARCH_REGS(10), .RESTORE_WIDTH(4), .DRAIN_TIMEOUT(16)) u_dut10 (
    .clk_in(clk_in), .rst_in(rst_in), .mispredict_valid_in(mp_valid),
    .mispredict_pc_in(mp_pc), .fu_busy_in(fu_busy), .redirect_ready_in(rdy),
    .flush_out(flush_b), .stall_out(stall_b), .restore_valid_out(rv_b),
    .restore_base_out(base_b), .restore_lane_valid_out(lanes_b),
    .redirect_valid_out(redv_b), .redirect_pc_out(rpc_b), .busy_out(busy_b),
    .drain_timeout_out(to_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; return just after the edge
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && busy_a !== 1'b0; i++) step();
    check("wait_idle", busy_a, 1'b0);
  endtask

  task automatic wait_redirect(input int max_cyc);
    for (int i = 0; i < max_cyc && redv_a !== 1'b1; i++) step();
    check("wait_redirect", redv_a, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // ---------------- reset state ----------------
    #2;
    check("rst_busy", busy_a, 1'b0);
    check("rst_pc", rpc_a, 64'h0);
    step(); step();
    rst_in = 1'b0;
    check("idle_stall", stall_a, 1'b0);
    check("idle_flush", flush_a, 1'b0);
    check("idle_rv", rv_a, 1'b0);
    check("idle_to", to_a, 1'b0);

    // ---------------- basic recovery + partial beat ----------------
    rdy = 1'b1; fu_busy = 4'b0000;
    mp_valid = 1'b1; mp_pc = 64'h4000;
    step();                                    // T+1
    mp_valid = 1'b0;
    check("b_flush_t1", flush_a, 1'b1);
    check("b_stall_t1", stall_a, 1'b1);
    check("b_busy_t1", busy_a, 1'b1);
    check("b_rv_t1", rv_a, 1'b0);
    check("b10_flush_t1", flush_b, 1'b1);
    step();                                    // T+2 DRAIN
    check("b_flush_t2", flush_a, 1'b0);
    check("b_rv_t2", rv_a, 1'b0);
    check("b_stall_t2", stall_a, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step();                                  // T+3+k
      check("b_rv", rv_a, 1'b1);
      check("b_base", base_a, 64'(4 * k));
      check("b_lanes", lanes_a, 4'b1111);
      check("b_flush", flush_a, 1'b0);
      check("b_redv", redv_a, 1'b0);
      if (k < 3) begin
        check("b10_rv", rv_b, 1'b1);
        check("b10_base", base_b, 64'(4 * k));
        check("b10_lanes", lanes_b, (k == 2) ? 4'b0011 : 4'b1111);
      end
      if (k == 3) begin
        check("b10_rv_done", rv_b, 1'b0);
        check("b10_redv", redv_b, 1'b1);
        check("b10_rpc", rpc_b, 64'h4000);
      end
      if (k == 4) check("b10_idle", busy_b, 1'b0);
    end
    step();                                    // T+11
    check("b_redv_t11", redv_a, 1'b1);
    check("b_rpc_t11", rpc_a, 64'h4000);
    check("b_rv_t11", rv_a, 1'b0);
    step();                                    // T+12
    check("b_busy_t12", busy_a, 1'b0);
    check("b_stall_t12", stall_a, 1'b0);
    check("b_redv_t12", redv_a, 1'b0);

    // ---------------- drain wait on LSU ----------------
    fu_busy = 4'b0010;
    mp_valid = 1'b1; mp_pc = 64'h8000;
    step();                                    // T+1
    mp_valid = 1'b0;
    check("d_flush", flush_a, 1'b1);
    for (int j = 0; j < DRAIN_CYC; j++) begin
      step();
      check("d_rv_hold", rv_a, 1'b0);
      check("d_stall_hold", stall_a, 1'b1);
    end
    step();
    fu_busy = 4'b0000;
    check("d_rv_clear_cyc", rv_a, 1'b0);
    check("d_stall_clear_cyc", stall_a, 1'b1);
    step();
    check("d_rv_first", rv_a, 1'b1);
    check("d_base_first", base_a, 64'h0);
    wait_redirect(20);
    check("d_rpc", rpc_a, 64'h8000);
    wait_idle(20);

    // ---------------- backpressure + ignored mispredicts ----------------
    rdy = 1'b0;
    mp_valid = 1'b1; mp_pc = 64'hC0DE;
    step();                                    // T+1
    mp_valid = 1'b0;
    check("p_flush", flush_a, 1'b1);
    step();                                    // T+2
    step();                                    // T+3
    mp_valid = 1'b1; mp_pc = 64'hDEAD;
    for (int j = 0; j < 7; j++) begin
      step();                                  // T+4..T+10
      check("p_noflush_restore", flush_a, 1'b0);
    end
    step();                                    // T+11
    check("p_redv", redv_a, 1'b1);
    check("p_rpc", rpc_a, 64'hC0DE);
    for (int j = 0; j < 5; j++) begin
      step();                                  // T+12..T+16
      check("p_redv_hold", redv_a, 1'b1);
      check("p_rpc_hold", rpc_a, 64'hC0DE);
      check("p_noflush_redirect", flush_a, 1'b0);
    end
    rdy = 1'b1;                                // handshake at end of T+16, mispredict still high
    step();                                    // T+17
    mp_valid = 1'b0;
    check("p_idle", busy_a, 1'b0);
    check("p_flush_ignored", flush_a, 1'b0);
    check("p_redv_low", redv_a, 1'b0);
    mp_valid = 1'b1; mp_pc = 64'h1234;         // first IDLE cycle
    step();
    mp_valid = 1'b0;
    check("p_new_flush", flush_a, 1'b1);
    wait_redirect(20);
    check("p_new_rpc", rpc_a, 64'h1234);
    wait_idle(20);

    // ---------------- async reset mid-RESTORE ----------------
    mp_valid = 1'b1; mp_pc = 64'h5555;
    step();                                    // T+1
    mp_valid = 1'b0;
    step(); step(); step(); step();            // T+5 = beat 2
    check("r_base_beat2", base_a, 64'h8);
    #3;
    rst_in = 1'b1;
    #1;
    check("r_busy", busy_a, 1'b0);
    check("r_stall", stall_a, 1'b0);
    check("r_rv", rv_a, 1'b0);
    check("r_base", base_a, 64'h0);
    check("r_lanes", lanes_a, 4'b0000);
    check("r_redv", redv_a, 1'b0);
    check("r_rpc", rpc_a, 64'h0);
    check("r_flush", flush_a, 1'b0);
    step();
    rst_in = 1'b0;
    mp_valid = 1'b1; mp_pc = 64'h6000;
    step();
    mp_valid = 1'b0;
    check("r2_flush", flush_a, 1'b1);
    step(); step();
    check("r2_rv", rv_a, 1'b1);
    check("r2_base0", base_a, 64'h0);
    check("r2_lanes", lanes_a, 4'b1111);
    step();
    check("r2_base1", base_a, 64'h4);
    wait_redirect(20);
    check("r2_rpc", rpc_a, 64'h6000);
    wait_idle(20);

`ifdef RECOVERY_DRAIN_TIMEOUT_EN
    // ---------------- stuck FPU drain timeout ----------------
    fu_busy = 4'b0100;
    mp_valid = 1'b1; mp_pc = 64'h7000;
    step();                                    // T+1
    mp_valid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      step();                                  // T+2..T+17
      check("t_rv_wait", rv_a, 1'b0);
      check("t_flag_wait", to_a, 1'b0);
    end
    step();                                    // T+18
    check("t_rv_forced", rv_a, 1'b1);
    check("t_flag_set", to_a, 1'b1);
    check("t10_flag_set", to_b, 1'b1);
    fu_busy = 4'b0000;
    wait_idle(30);
    mp_valid = 1'b1; mp_pc = 64'h7100;
    step();
    mp_valid = 1'b0;
    check("t_flag_sticky", to_a, 1'b1);
    wait_idle(30);
    check("t_flag_sticky_end", to_a, 1'b1);
`else
    check("nt_flag_a", to_a, 1'b0);
    check("nt_flag_b", to_b, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/recovery_ctrl.md
# recovery_ctrl

Backend misprediction recovery sequencer. On a resolved mispredicted branch from the ROB it flushes the ROB and functional units, waits for in-flight FU work to drain, and copies the RRAT into the RAT in fixed-width beats. It then redirects fetch to the corrected PC. It sits between the ROB branch-writeback output and the RAT/RRAT, the FU decoders, and the branch predictor/fetch redirect path. It also drives the dispatch stall that gates `ready_out`.

## Interface
Parameters:
- NUM_ARCH_REGS, 32: architectural register mappings to restore.
- RESTORE_WIDTH, 4: RRAT-to-RAT mappings copied per cycle; must be at least 1.
- DRAIN_TIMEOUT, 256: maximum DRAIN cycles; used only when the timeout feature is compiled in.

Ports:
- clk_in, input, 1: clock. Single clock domain.
- rst_in, input, 1: reset, asynchronous, active-high.
- mispredict_valid_in, input, 1: a committing branch resolved with a wrong prediction.
- mispredict_pc_in, input, 64: corrected fetch PC.
- fu_busy_in, input, 4: FUs with work in flight, ordered {alu, fpu, lsu, bru}.
- redirect_ready_in, input, 1: fetch accepts the redirect.
- flush_out, output, 1: one-cycle flush pulse to the ROB and all FU decoders.
- stall_out, output, 1: blocks RAT dispatch and queue increment.
- restore_valid_out, output, 1: a restore beat is active this cycle.
- restore_base_out, output, $clog2(NUM_ARCH_REGS): first architectural index of the beat.
- restore_lane_valid_out, output, RESTORE_WIDTH: per-lane enable; lane i restores index base+i.
- redirect_valid_out, output, 1: fetch redirect request.
- redirect_pc_out, output, 64: corrected PC.
- busy_out, output, 1: the FSM is not in IDLE.
- drain_timeout_out, output, 1: sticky drain-timeout error.

## Operation
FSM states are IDLE, FLUSH, DRAIN, RESTORE and REDIRECT.
- **IDLE:** when mispredict_valid_in=1, latch mispredict_pc_in and go to FLUSH.
- **FLUSH:** flush_out=1 for exactly this cycle. Clear the beat counter. Go to DRAIN.
- **DRAIN:** go to RESTORE on the first cycle fu_busy_in==4'b0000 is sampled. The state lasts at least one cycle.
- **RESTORE:** runs B = ceil(NUM_ARCH_REGS/RESTORE_WIDTH) beats.
  - Beat k drives restore_base_out = k*RESTORE_WIDTH.
  - Lane i is valid iff k*RESTORE_WIDTH+i < NUM_ARCH_REGS, so only the final beat can be partial.
  - After beat B-1, go to REDIRECT.
- **REDIRECT:** redirect_valid_out=1 with redirect_pc_out = the latched PC. Both hold stable until redirect_ready_in=1 is sampled, then go to IDLE.
- stall_out = 1 in every non-IDLE state.
- mispredict_valid_in is ignored outside IDLE. Mispredicts arrive at commit only, so any later one belongs to flushed work.
- Reset mid-operation: the FSM returns to IDLE immediately and the in-progress restore is abandoned. The RAT/RRAT reset independently.

## Timing
- Every output resets to 0, including redirect_pc_out and drain_timeout_out.
- All outputs are registered from state; there is no combinational input-to-output path.
- Mispredict sampled at edge T:
  - flush_out and stall_out are high during T+1.
  - DRAIN is entered at T+2.
  - With fu_busy_in already 0 at T+2, restore beats run T+3 through T+2+B.
  - redirect_valid_out rises at T+3+B.
  - Minimum recovery is B+3 cycles before a same-cycle redirect handshake.
- Each beat lasts exactly one cycle; the RAT writes on the edge ending the beat.
- Redirect handshake completes on the edge where valid and ready are both 1. busy_out and stall_out drop in the following cycle.
- A mispredict presented in the handshake cycle is ignored.
- A mispredict presented in the first IDLE cycle after it starts a new recovery.

## Configuration
- RECOVERY_DRAIN_TIMEOUT_EN defined:
  - DRAIN counts cycles.
  - If fu_busy_in is still nonzero after DRAIN_TIMEOUT cycles, set drain_timeout_out (sticky until reset) and force the transition to RESTORE.
- RECOVERY_DRAIN_TIMEOUT_EN undefined:
  - DRAIN waits indefinitely.
  - drain_timeout_out is tied to 0 and no counter is built.

## Structure
- recovery_pkg holds:
  - the recovery_state_t enum;
  - FU bit-index constants FU_ALU=3, FU_FPU=2, FU_LSU=1, FU_BRU=0.
- Beat count B and the lane-mask function are localparams/functions inside the module.
- One sub-module, recovery_drain_watchdog, holds the timeout counter. It is instantiated only under RECOVERY_DRAIN_TIMEOUT_EN.

## Test plan
- **Basic recovery:** NUM_ARCH_REGS=32, RESTORE_WIDTH=4, fu_busy_in=0, redirect_ready_in=1, mispredict with PC 0x4000 at T.
  - flush_out pulses only in T+1.
  - 8 beats with bases 0,4,…,28, all lane masks 4'b1111.
  - redirect_pc_out=0x4000 at T+11; busy_out=0 at T+12.
- **Partial beat:** NUM_ARCH_REGS=10, RESTORE_WIDTH=4.
  - 3 beats with bases 0,4,8 and masks 1111, 1111, 0011.
- **Drain wait:** fu_busy_in=4'b0010 (LSU) for 20 cycles after FLUSH.
  - No restore_valid_out until the cycle after fu_busy_in clears.
  - stall_out is held throughout.
- **Redirect backpressure plus ignored mispredicts:**
  - redirect_ready_in=0 for 5 cycles: redirect_valid_out and redirect_pc_out stay stable.
  - Extra mispredicts during RESTORE and REDIRECT: no second flush_out.
- **Async reset:** assert rst_in mid-RESTORE, off-edge.
  - All outputs go to 0 immediately.
  - The next mispredict runs a full recovery starting at base 0.
- **Timeout, with RECOVERY_DRAIN_TIMEOUT_EN and DRAIN_TIMEOUT=16:** fu_busy_in stuck at 4'b0100.
  - drain_timeout_out sets after 16 DRAIN cycles and RESTORE begins.
  - drain_timeout_out stays 1 through the next recovery.
